// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Four-requester round-robin arbiter driving a shared 4:1 data mux. A granted
// requester keeps ownership for up to MAX_BURST transfers, then ownership
// rotates. The next owner is chosen at the same edge as the release, so there
// is no idle bubble between owners.
//
// Handshake: a word moves from the owner to downstream in any cycle where
// out_valid=1 and out_ready=1. In that cycle ack[sel] pulses high. out_valid
// mirrors req[sel], so a requester that drops req loses the grant at the next
// edge without being acked.
//
// Parameters
//   DATA_W     width of each requester word
//   MAX_BURST  transfers per grant before forced rotation (1..15)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        request line per requester 0..3
//   data_in    requester i word at [i*DATA_W +: DATA_W]
//   out_ready  downstream accepts out_data this cycle
//   grant      one-hot current owner, zero when idle
//   sel        binary index of the current owner (mux select)
//   out_data   owner's word, zero when idle or in reset
//   out_valid  out_data is valid
//   ack        per-requester transfer pulse
//   dbg_busy   FSM state (1 = BUSY)
//   dbg_count  transfers completed in the current grant
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic                  out_ready,
    output logic [3:0]            grant,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic [3:0]            ack,
    output logic                  dbg_busy,
    output logic [3:0]            dbg_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_t      state;
    logic [3:0]  count;
    logic [1:0]  ptr;

    logic [DATA_W-1:0] words [4];
    logic        active;
    logic        owner_req;
    logic        transfer;
    logic        burst_done;
    logic        release_now;
    logic [1:0]  next_ptr;
    logic [1:0]  arb_ptr;
    logic [1:0]  winner;
    logic        any_req;

    // First asserted request scanning p, p+1, p+2, p+3 (mod 4). Scanning from
    // the far end downward lets the nearest hit overwrite the result last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            words[i] = data_in[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        active      = (state == BUSY) && !reset;
        owner_req   = req[sel];
        out_valid   = active && owner_req;
        out_data    = active ? words[sel] : '0;
        transfer    = out_valid && out_ready;
        ack         = transfer ? (4'b0001 << sel) : 4'b0000;
        burst_done  = transfer && ((count + 4'd1) == BURST_LIMIT);
        release_now = (state == BUSY) && (!owner_req || burst_done);
        next_ptr    = sel + 2'd1;
        // On release the new pointer is already in effect for this edge's pick.
        arb_ptr     = (state == BUSY) ? next_ptr : ptr;
        winner      = rr_pick(req, arb_ptr);
        any_req     = |req;
        dbg_busy    = (state == BUSY);
        dbg_count   = count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= 4'b0001 << winner;
                        sel   <= winner;
                        count <= 4'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr   <= next_ptr;
                        count <= 4'd0;
                        if (any_req) begin
                            grant <= 4'b0001 << winner;
                            sel   <= winner;
                        end else begin
                            grant <= 4'b0000;
                            state <= IDLE;
                        end
                    end else if (transfer) begin
                        count <= count + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3:0]      req;
  logic [DW-1:0]   w [4];
  logic [4*DW-1:0] data_in;
  logic            out_ready;
  logic [3:0]      grant;
  logic [1:0]      sel;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [3:0]      ack;
  logic            dbg_busy;
  logic [3:0]      dbg_count;

  assign data_in = {w[3], w[2], w[1], w[0]};

  mux_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .out_ready(out_ready), .grant(grant), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .ack(ack), .dbg_busy(dbg_busy), .dbg_count(dbg_count)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // owner = -1 means idle; ptr and cnt are plain integers.
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_update();
    bit xfer;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      m_owner = first_from(req, m_ptr);
      m_cnt = 0;
    end else begin
      xfer = req[m_owner] && out_ready;
      if (!req[m_owner] || (xfer && (m_cnt + 1 == MB))) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = first_from(req, m_ptr);
        m_cnt = 0;
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; the model follows every edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; out_ready = 1'b1; rand_words();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 00", out_data); end
    step();
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (dbg_busy !== 1'b0) begin failures++; $display("FAIL reset_state: got %b want 0", dbg_busy); end
    checks++; if (dbg_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dbg_count); end
    reset = 1'b0; req = 4'b0000;
    step();
  endtask

  task automatic test_single();
    reset_dut();
    req = 4'b0001; w[0] = 8'hA5; out_ready = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin failures++; $display("FAIL single_idle: grant=%b valid=%b want 0000/0", grant, out_valid); end
    step();
    #1;
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", grant); end
    checks++; if (sel !== 2'd0) begin failures++; $display("FAIL single_sel: got %0d want 0", sel); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", out_data); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL single_ack: got %b want 0001", ack); end
    step();
    req = 4'b0000;
    step();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    int o;
    reset_dut();
    rand_words();
    req = 4'b1111; out_ready = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      #1;
      o = (i / 4) % 4;
      exp_g = 4'b0001 << o;
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rot_grant[%0d]: got %b want %b", i, grant, exp_g); end
      checks++; if (ack !== exp_g) begin failures++; $display("FAIL rot_ack[%0d]: got %b want %b", i, ack, exp_g); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rot_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (out_data !== w[o]) begin failures++; $display("FAIL rot_data[%0d]: got %h want %h", i, out_data, w[o]); end
      checks++; if (dbg_count !== 4'(i % 4)) begin failures++; $display("FAIL rot_count[%0d]: got %0d want %0d", i, dbg_count, i % 4); end
      step();
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    reset_dut();
    req = 4'b0001; out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL bp_grant[%0d]: got %b want 0001", i, grant); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL bp_ack[%0d]: got %b want 0000", i, ack); end
      checks++; if (dbg_count !== 4'd1) begin failures++; $display("FAIL bp_count[%0d]: got %0d want 1", i, dbg_count); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL bp_resume_ack: got %b want 0001", ack); end
    step();
    #1;
    checks++; if (dbg_count !== 4'd2) begin failures++; $display("FAIL bp_resume_count: got %0d want 2", dbg_count); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_abandon();
    reset_dut();
    req = 4'b0001; out_ready = 1'b1;
    step();
    step();
    step();
    req = 4'b0100;
    #1;
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL abandon_ack: got %b want 0000", ack); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abandon_valid: got %b want 0", out_valid); end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL abandon_hold: got %b want 0001", grant); end
    step();
    #1;
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL abandon_grant: got %b want 0100", grant); end
    checks++; if (sel !== 2'd2) begin failures++; $display("FAIL abandon_sel: got %0d want 2", sel); end
    checks++; if (dbg_count !== 4'd0) begin failures++; $display("FAIL abandon_count: got %0d want 0", dbg_count); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    req = 4'b0001; out_ready = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rmid_ack: got %b want 0000", ack); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rmid_data: got %h want 00", out_data); end
    step();
    reset = 1'b0; req = 4'b1010;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rmid_grant0: got %b want 0000", grant); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid0: got %b want 0", out_valid); end
    step();
    #1;
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rmid_regrant: got %b want 0010", grant); end
    checks++; if (sel !== 2'd1) begin failures++; $display("FAIL rmid_sel: got %0d want 1", sel); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_lone();
    reset_dut();
    req = 4'b0010; out_ready = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL lone_grant[%0d]: got %b want 0010", i, grant); end
      checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL lone_ack[%0d]: got %b want 0010", i, ack); end
      checks++; if (dbg_count !== 4'(i % 4)) begin failures++; $display("FAIL lone_count[%0d]: got %0d want %0d", i, dbg_count, i % 4); end
      step();
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_random();
    logic [3:0]    exp_g;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [3:0]    exp_a;
    reset_dut();
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
        if (!req[b]) w[b] = DW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 39) == 0);
      #1;
      exp_g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      exp_v = !reset && (m_owner >= 0) && req[m_owner];
      exp_d = (!reset && m_owner >= 0) ? w[m_owner] : '0;
      exp_a = (exp_v && out_ready) ? exp_g : 4'b0000;
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rnd_grant[%0d]: got %b want %b", i, grant, exp_g); end
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, exp_v); end
      checks++; if (out_data !== exp_d) begin failures++; $display("FAIL rnd_data[%0d]: got %h want %h", i, out_data, exp_d); end
      checks++; if (ack !== exp_a) begin failures++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, ack, exp_a); end
      checks++; if (dbg_count !== 4'(m_cnt)) begin failures++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, dbg_count, m_cnt); end
      if (m_owner >= 0) begin
        checks++; if (sel !== 2'(m_owner)) begin failures++; $display("FAIL rnd_sel[%0d]: got %0d want %0d", i, sel, m_owner); end
      end
      checks++; if (!$onehot0(grant) || ((ack & ~grant) != 4'b0000)) begin failures++; $display("FAIL rnd_onehot[%0d]: grant=%b ack=%b", i, grant, ack); end
      step();
    end
    reset = 1'b0; req = 4'b0000;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
    rand_words();
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_abandon();
    test_reset_mid();
    test_lone();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
